// File: rtl/systolic_tile_engine.sv
// rtl/systolic_tile_engine.sv - output-stationary ROWSxCOLS systolic matrix-multiply tile engine
// Streams K operand beats through skewed row/column chains and drains C one row per handshake.
module systolic_tile_engine #(
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int IP_WIDTH  = 8,
   parameter int ACC_WIDTH = 32,
   parameter int SAT_EN    = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [15:0]                k_len,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ROWS*IP_WIDTH-1:0]   a_vec,
   input  logic [COLS*IP_WIDTH-1:0]   b_vec,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [COLS*ACC_WIDTH-1:0]  out_row,
   output logic [$clog2(ROWS)-1:0]    out_row_idx,
   output logic                       busy,
   output logic                       done,
   output logic                       err_start,
   output logic [31:0]                cycles_count
);

   localparam int RW    = $clog2(ROWS);
   localparam int DEPTH = ROWS + COLS - 1;
   localparam int FW    = $clog2(DEPTH);
   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [15:0]       k_q;
   logic [15:0]       beat_q;
   logic [FW-1:0]     flush_q;
   logic [RW-1:0]     row_q;
   logic              done_q;
   logic              err_q;
   logic [31:0]       cyc_q;
   logic [DEPTH-1:0]  vd;

   logic accept, launch, last_beat, flush_end, row_hs, last_row;

   logic signed [ACC_WIDTH-1:0] acc_w [ROWS][COLS];

   assign accept    = in_valid && in_ready;
   assign launch    = start && (state_q == IDLE);
   assign last_beat = accept && (beat_q == k_q - 16'd1);
   assign flush_end = (state_q == FLUSH) && (flush_q == FW'(DEPTH - 1));
   assign row_hs    = out_valid && out_ready;
   assign last_row  = row_hs && (row_q == RW'(ROWS - 1));

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) state_d = (k_len == 16'd0) ? DRAIN : LOAD;
         end
         LOAD: begin
            in_ready = 1'b1;
            if (last_beat) state_d = FLUSH;
         end
         FLUSH: begin
            if (flush_end) state_d = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (last_row) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         beat_q  <= '0;
         flush_q <= '0;
         row_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cyc_q   <= '0;
         vd      <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= last_row;
         err_q   <= start && (state_q != IDLE);
         vd      <= {vd[DEPTH-2:0], accept};
         if (launch) begin
            k_q    <= k_len;
            beat_q <= '0;
            cyc_q  <= '0;
            row_q  <= '0;
         end else begin
            if (state_q != IDLE) cyc_q <= cyc_q + 32'd1;
            if (accept) beat_q <= beat_q + 16'd1;
            if (row_hs) row_q <= last_row ? '0 : row_q + 1'b1;
         end
         flush_q <= (state_q == FLUSH && !flush_end) ? flush_q + 1'b1 : '0;
      end
   end

   // Row i chain: element d holds the operand accepted d+1 cycles ago; PE(i,j) taps i+j.
   for (genvar i = 0; i < ROWS; i++) begin : g_row
      logic signed [IP_WIDTH-1:0] ak [0:i+COLS-1];
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int d = 0; d < i + COLS; d++) ak[d] <= '0;
         end else begin
            ak[0] <= accept ? a_vec[i*IP_WIDTH +: IP_WIDTH] : '0;
            for (int d = 1; d < i + COLS; d++) ak[d] <= ak[d-1];
         end
      end
   end

   for (genvar j = 0; j < COLS; j++) begin : g_col
      logic signed [IP_WIDTH-1:0] bk [0:j+ROWS-1];
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int d = 0; d < j + ROWS; d++) bk[d] <= '0;
         end else begin
            bk[0] <= accept ? b_vec[j*IP_WIDTH +: IP_WIDTH] : '0;
            for (int d = 1; d < j + ROWS; d++) bk[d] <= bk[d-1];
         end
      end
   end

   for (genvar i = 0; i < ROWS; i++) begin : g_pe_r
      for (genvar j = 0; j < COLS; j++) begin : g_pe_c
         logic signed [IP_WIDTH-1:0]    a_op, b_op;
         logic signed [2*IP_WIDTH-1:0]  prod;
         logic signed [ACC_WIDTH-1:0]   acc_q, acc_n;

         assign a_op = g_row[i].ak[i+j];
         assign b_op = g_col[j].bk[i+j];
         assign prod = (2*IP_WIDTH)'(a_op) * (2*IP_WIDTH)'(b_op);

         if (SAT_EN != 0) begin : g_sat
            logic signed [ACC_WIDTH:0] sum;
            assign sum = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(prod);
            always_comb begin
               acc_n = sum[ACC_WIDTH-1:0];
               if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) acc_n = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            end
         end else begin : g_wrap
            assign acc_n = acc_q + ACC_WIDTH'(prod);
         end

         always_ff @(posedge clk) begin
            if (rst || launch) acc_q <= '0;
            else if (vd[i+j]) acc_q <= acc_n;
         end

         assign acc_w[i][j] = acc_q;
      end
   end

   always_comb begin
      out_row = '0;
      if (out_valid) begin
         for (int j = 0; j < COLS; j++) out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc_w[row_q][j];
      end
   end

   assign out_row_idx  = row_q;
   assign done         = done_q;
   assign err_start    = err_q;
   assign cycles_count = cyc_q;

endmodule
